// File: rtl/row_scheduler.sv
// row_scheduler: sequences row generation and multi-plane scanning over a ping-pong line buffer.
module row_scheduler #(
  parameter int ROW_COUNT   = 32,
  parameter int PLANE_COUNT = 1,
  parameter int FRAME_WIDTH = 10,
  localparam int RW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1,
  localparam int PW = (PLANE_COUNT > 1) ? $clog2(PLANE_COUNT) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   generator_start,
  input  logic                   generator_is_idle,
  output logic [RW-1:0]          generator_y,
  output logic                   generator_bank,
  output logic [FRAME_WIDTH-1:0] generator_frame,
  output logic                   driver_start,
  input  logic                   driver_is_idle,
  output logic [RW-1:0]          driver_y,
  output logic                   driver_bank,
  output logic [PW-1:0]          driver_plane,
  output logic [FRAME_WIDTH-1:0] frame_count,
  output logic                   frame_done,
  output logic                   busy
);
  localparam logic [2:0] kIdle      = 3'd0;
  localparam logic [2:0] kPrime     = 3'd1;
  localparam logic [2:0] kPrimeArm  = 3'd2;
  localparam logic [2:0] kPrimeWait = 3'd3;
  localparam logic [2:0] kStart     = 3'd4;
  localparam logic [2:0] kArm       = 3'd5;
  localparam logic [2:0] kWait      = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [RW-1:0]          y_q, y_d, next_y;
  logic [PW-1:0]          plane_q, plane_d;
  logic                   bank_q, bank_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   done_q, done_d;
  logic                   last_row, last_plane, boundary, in_slot;

  assign last_row   = y_q == RW'(ROW_COUNT - 1);
  assign last_plane = plane_q == PW'(PLANE_COUNT - 1);
  assign next_y     = last_row ? '0 : y_q + 1'b1;
  assign boundary   = state_q == kWait && generator_is_idle && driver_is_idle;
  assign in_slot    = state_q == kStart || state_q == kArm || state_q == kWait;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    plane_d = plane_q;
    bank_d  = bank_q;
    done_d  = boundary && last_plane && last_row;
    frame_d = done_d ? frame_q + 1'b1 : frame_q;
    case (state_q)
      kIdle:      state_d = enable ? kPrime : kIdle;
      kPrime:     state_d = kPrimeArm;
      kPrimeArm:  state_d = kPrimeWait;
      kPrimeWait: state_d = generator_is_idle ? kStart : kPrimeWait;
      kStart:     state_d = kArm;
      kArm:       state_d = kWait;
      kWait: if (boundary) begin
        // a stopping boundary parks the pointers at row 0 so a restart re-primes cleanly
        state_d = enable ? kStart : kIdle;
        plane_d = (last_plane || !enable) ? '0 : plane_q + 1'b1;
        y_d     = !enable ? '0 : (last_plane ? next_y : y_q);
        bank_d  = enable && (bank_q ^ last_plane);
      end
      default:    state_d = kIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= kIdle;
      y_q     <= '0;
      plane_q <= '0;
      bank_q  <= 1'b0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      plane_q <= plane_d;
      bank_q  <= bank_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign busy            = state_q != kIdle;
  assign driver_start    = state_q == kStart;
  assign generator_start = state_q == kPrime || (driver_start && plane_q == '0);
  assign generator_y     = in_slot ? next_y : '0;
  assign generator_bank  = in_slot && !bank_q;
  assign generator_frame = (in_slot && last_row) ? frame_q + 1'b1 : frame_q;
  assign driver_y        = y_q;
  assign driver_bank     = bank_q;
  assign driver_plane    = plane_q;
  assign frame_count     = frame_q;
  assign frame_done      = done_q;
endmodule

// File: tb/tb_row_scheduler.sv
// tb_row_scheduler: directed vectors, corner sequences and randomized run against a slot-index reference model.
module tb_row_scheduler;
  localparam int R = 4, P = 3, FW = 3;

  logic clock = 1'b0;
  logic reset, enable, generator_is_idle, driver_is_idle;
  logic generator_start, driver_start, busy, frame_done, generator_bank, driver_bank;
  logic [1:0] generator_y, driver_y, driver_plane;
  logic [FW-1:0] generator_frame, frame_count;
  logic [17:0] obs;

  row_scheduler #(.ROW_COUNT(R), .PLANE_COUNT(P), .FRAME_WIDTH(FW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .generator_start(generator_start), .generator_is_idle(generator_is_idle),
    .generator_y(generator_y), .generator_bank(generator_bank), .generator_frame(generator_frame),
    .driver_start(driver_start), .driver_is_idle(driver_is_idle),
    .driver_y(driver_y), .driver_bank(driver_bank), .driver_plane(driver_plane),
    .frame_count(frame_count), .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  assign obs = {generator_start, driver_start, busy, frame_done, driver_y, driver_plane, driver_bank,
                generator_y, generator_bank, generator_frame, frame_count};

  typedef struct {
    logic rst, en, gi, di;
    logic [17:0] exp;
  } vec_t;
  vec_t q[$];

  int total = 0, bad = 0;
  int phase, age, s, m_frame, m_done, nd;
  int g_age, d_age, g_del, d_del, cyc, last_ds, last_gap;
  bit rnd;

  function automatic logic [17:0] mk(int gs, int ds, int bz, int fd, int dy, int pl, int db,
                                     int gy, int gb, int gf, int fc);
    return {1'(gs), 1'(ds), 1'(bz), 1'(fd), 2'(dy), 2'(pl), 1'(db), 2'(gy), 1'(gb), 3'(gf), 3'(fc)};
  endfunction

  task automatic add(input int rst, input int en, input logic [17:0] e);
    vec_t v;
    v.rst = 1'(rst); v.en = 1'(en); v.gi = 1'b1; v.di = 1'b1; v.exp = e;
    q.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs derived from the slot index since the last prime
  function automatic logic [17:0] model_exp();
    int row = (s / P) % R, pl = s % P, bk = (s / P) % 2;
    if (phase == 2)
      return mk(age == 0 && pl == 0, age == 0, 1, m_done, row, pl, bk, (row + 1) % R, 1 - bk,
                (m_frame + (row == R - 1 ? 1 : 0)) % (1 << FW), m_frame);
    return mk(phase == 1 && age == 0, 0, phase != 0, m_done, 0, 0, 0, 0, 0, m_frame, m_frame);
  endfunction

  task automatic step(input logic rst_v, input logic en_v);
    check($sformatf("cyc%0d", cyc), obs, model_exp());
    if (driver_start) begin
      if (last_ds >= 0) last_gap = cyc - last_ds;
      last_ds = cyc;
    end
    if (generator_start) begin
      g_age = 0;
      if (rnd) g_del = $urandom_range(1, 8);
    end else if (g_age >= 0) begin
      g_age++;
      generator_is_idle = g_age >= g_del;
      if (generator_is_idle) g_age = -1;
    end
    if (driver_start) begin
      d_age = 0;
      if (rnd) d_del = $urandom_range(1, 12);
    end else if (d_age >= 0) begin
      d_age++;
      driver_is_idle = d_age >= d_del;
      if (driver_is_idle) d_age = -1;
    end
    reset = rst_v;
    enable = en_v;
    if (rst_v) begin
      phase = 0; age = 0; s = 0; m_frame = 0; m_done = 0;
    end else begin
      nd = 0;
      if (phase == 0) begin
        if (en_v) begin phase = 1; age = 0; end
      end else if (phase == 1) begin
        if (age >= 2 && generator_is_idle) begin phase = 2; age = 0; s = 0; end
        else age++;
      end else begin
        if (age >= 2 && generator_is_idle && driver_is_idle) begin
          if ((s + 1) % (P * R) == 0) begin m_frame = (m_frame + 1) % (1 << FW); nd = 1; end
          if (en_v) begin s++; age = 0; end
          else phase = 0;
        end else age++;
      end
      m_done = nd;
    end
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    logic fd_seen, en_r;
    reset = 1'b1; enable = 1'b0; generator_is_idle = 1'b1; driver_is_idle = 1'b1;
    add(1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, mk(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 1, mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 1, mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 1, mk(0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0));
    add(0, 1, mk(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0));
    add(0, 1, mk(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0));
    add(0, 1, mk(0, 1, 1, 0, 0, 2, 0, 1, 1, 0, 0));
    add(0, 1, mk(0, 0, 1, 0, 0, 2, 0, 1, 1, 0, 0));
    add(0, 1, mk(0, 0, 1, 0, 0, 2, 0, 1, 1, 0, 0));
    add(0, 1, mk(1, 1, 1, 0, 1, 0, 1, 2, 0, 0, 0));
    foreach (q[i]) begin
      reset = q[i].rst; enable = q[i].en;
      generator_is_idle = q[i].gi; driver_is_idle = q[i].di;
      @(negedge clock);
      check($sformatf("vec%0d", i), obs, q[i].exp);
    end

    reset = 1'b1; enable = 1'b0; generator_is_idle = 1'b1; driver_is_idle = 1'b1;
    @(negedge clock);
    phase = 0; age = 0; s = 0; m_frame = 0; m_done = 0;
    g_age = -1; d_age = -1; rnd = 0; g_del = 5; d_del = 20; cyc = 0; last_ds = -1; last_gap = -1;

    repeat (100) step(1'b0, 1'b1);
    check("slow gap", last_gap, 21);

    g_del = 1; d_del = 1;
    for (int k = 0; k < 2000 && !(frame_count == 5 && driver_y == 2 && driver_start); k++) step(1'b0, 1'b1);
    check("reach f5r2", {frame_count, driver_y, driver_start}, {3'd5, 2'd2, 1'b1});
    fd_seen = 1'b0;
    for (int k = 0; k < 100 && busy; k++) begin
      step(1'b0, 1'b0);
      fd_seen |= frame_done;
    end
    check("stop busy", busy, 0);
    check("stop ptrs", {driver_y, driver_plane, driver_bank}, 0);
    check("stop frame", frame_count, 5);
    check("stop no done", fd_seen, 0);
    step(1'b0, 1'b1);
    check("restart prime", {generator_start, generator_y, generator_bank}, {1'b1, 2'd0, 1'b0});

    for (int k = 0; k < 2000 && frame_count != 7; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 200 && frame_count == 7; k++) step(1'b0, 1'b1);
    check("wrap fc", frame_count, 0);
    check("wrap fd", frame_done, 1);

    d_del = 10;
    for (int k = 0; k < 200 && !driver_start; k++) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    check("pre-reset busy", busy, 1);
    step(1'b1, 1'b1);
    check("reset mid-wait", obs, 0);

    rnd = 1; en_r = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 29) == 0) en_r = ~en_r;
      step($urandom_range(0, 399) == 0, en_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
